culsans_axi_scratchpad: RTL and testbench

AXI4/ACE-lite responder (subordinate) that terminates one crossbar slave port with a word-addressed scratchpad of 64-bit words. It is the responder end of the crossbar request/response structs used on the slave side (`req_slv_t` / `resp_slv_t`, wide IDs). Write and read paths each run their own state machine with one outstanding transaction per path. Intended uses are simulation/FPGA shared-memory windows and exit/mailbox regions behind the DRAM rule.

---
 rtl/culsans_axi_scratchpad.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_culsans_axi_scratchpad.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/culsans_axi_scratchpad.sv
// Scratchpad responder terminating one crossbar slave port with a 64-bit word array.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each.

package culsans_pkg;
    localparam int unsigned IdWidthSlv = 8;
    localparam int unsigned AddrWidth  = 64;
    localparam int unsigned DataWidth  = 64;
    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned UserWidth  = 1;

    localparam logic [AddrWidth-1:0] DRAMBase = 64'h0000_0000_8000_0000;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [AddrWidth-1:0]  addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [UserWidth-1:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [1:0]            resp;
        logic [UserWidth-1:0]  user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [AddrWidth-1:0]  addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [UserWidth-1:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [DataWidth-1:0]  data;
        logic [3:0]            resp;
        logic                  last;
        logic [UserWidth-1:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_slv_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_slv_t;
endpackage

// state  | meaning
// W_IDLE | aw_ready high, waiting for a write address
// W_DATA | w_ready high, accepting beats until the final one
// W_RESP | b_valid high until b_ready
// R_IDLE | ar_ready high, waiting for a read address
// R_DATA | r_valid high, one beat per r_ready until the last
module culsans_axi_scratchpad #(
    parameter int unsigned NumWords = 512,
    parameter logic [63:0] BaseAddr = culsans_pkg::DRAMBase
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  culsans_pkg::req_slv_t  axi_req_i,
    output culsans_pkg::resp_slv_t axi_resp_o
);
    import culsans_pkg::*;

    localparam int unsigned IdxW      = $clog2(NumWords);
    localparam logic [63:0] SpanBytes = 64'(NumWords) * 64'd8;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [63:0] r_mem [NumWords];

    logic [1:0]            r_w_state;
    logic [IdWidthSlv-1:0] r_w_id;
    logic [63:0]           r_w_addr;
    logic [7:0]            r_w_len;
    logic [7:0]            r_w_cnt;
    logic [2:0]            r_w_size;
    logic [1:0]            r_w_burst;
    logic                  r_w_err;

    logic [0:0]            r_r_state;
    logic [IdWidthSlv-1:0] r_r_id;
    logic [63:0]           r_r_addr;
    logic [7:0]            r_r_len;
    logic [7:0]            r_r_cnt;
    logic [2:0]            r_r_size;
    logic [1:0]            r_r_burst;
    logic                  r_r_err;

    logic            w_aw_err;
    logic            w_ar_err;
    logic [63:0]     w_w_off;
    logic            w_w_in_range;
    logic [IdxW-1:0] w_w_idx;
    logic            w_w_hs;
    logic            w_w_at_len;
    logic            w_w_final;
    logic            w_w_last_err;
    logic            w_w_do_write;
    logic [63:0]     w_w_next_addr;
    logic [63:0]     w_r_off;
    logic            w_r_in_range;
    logic [IdxW-1:0] w_r_idx;
    logic            w_r_beat_ok;
    logic [63:0]     w_r_data;
    logic [63:0]     w_r_next_addr;
    logic            w_unused;

    assign w_aw_err = (axi_req_i.aw.burst == BURST_WRAP) || (axi_req_i.aw.size > 3'd3) ||
                      (axi_req_i.aw.atop != 6'd0) || axi_req_i.aw.lock;
    assign w_ar_err = (axi_req_i.ar.burst == BURST_WRAP) || (axi_req_i.ar.size > 3'd3) ||
                      axi_req_i.ar.lock;

    // Range test uses the offset so BaseAddr + span never has to be formed without overflow.
    assign w_w_off       = r_w_addr - BaseAddr;
    assign w_w_in_range  = (r_w_addr >= BaseAddr) && (w_w_off < SpanBytes);
    assign w_w_idx       = w_w_off[3 +: IdxW];
    assign w_w_hs        = !rst_i && (r_w_state == W_DATA) && axi_req_i.w_valid;
    assign w_w_at_len    = (r_w_cnt == r_w_len);
    assign w_w_final     = w_w_at_len || axi_req_i.w.last;
    assign w_w_last_err  = w_w_at_len != axi_req_i.w.last;
    assign w_w_do_write  = w_w_hs && !r_w_err && w_w_in_range;
    assign w_w_next_addr = (r_w_burst == BURST_INCR) ? r_w_addr + (64'd1 << r_w_size) : r_w_addr;

    assign w_r_off       = r_r_addr - BaseAddr;
    assign w_r_in_range  = (r_r_addr >= BaseAddr) && (w_r_off < SpanBytes);
    assign w_r_idx       = w_r_off[3 +: IdxW];
    assign w_r_beat_ok   = !r_r_err && w_r_in_range;
    assign w_r_data      = w_r_beat_ok ? r_mem[w_r_idx] : 64'd0;
    assign w_r_next_addr = (r_r_burst == BURST_INCR) ? r_r_addr + (64'd1 << r_r_size) : r_r_addr;

    assign w_unused = ^{axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
                        axi_req_i.aw.region, axi_req_i.aw.user, axi_req_i.w.user,
                        axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.ar.qos,
                        axi_req_i.ar.region, axi_req_i.ar.user};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_w_state <= W_IDLE;
            r_w_id    <= '0;
            r_w_addr  <= '0;
            r_w_len   <= '0;
            r_w_cnt   <= '0;
            r_w_size  <= '0;
            r_w_burst <= '0;
            r_w_err   <= 1'b0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (axi_req_i.aw_valid) begin
                        r_w_id    <= axi_req_i.aw.id;
                        r_w_addr  <= axi_req_i.aw.addr;
                        r_w_len   <= axi_req_i.aw.len;
                        r_w_size  <= axi_req_i.aw.size;
                        r_w_burst <= axi_req_i.aw.burst;
                        r_w_err   <= w_aw_err;
                        r_w_cnt   <= 8'd0;
                        r_w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_req_i.w_valid) begin
                        r_w_addr <= w_w_next_addr;
                        r_w_cnt  <= r_w_cnt + 8'd1;
                        if (!w_w_in_range || w_w_last_err) begin
                            r_w_err <= 1'b1;
                        end
                        if (w_w_final) begin
                            r_w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_req_i.b_ready) begin
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; writes already done survive a reset.
    always_ff @(posedge clk_i) begin
        if (w_w_do_write) begin
            for (int k = 0; k < 8; k++) begin
                if (axi_req_i.w.strb[k]) begin
                    r_mem[w_w_idx][8*k +: 8] <= axi_req_i.w.data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_r_state <= R_IDLE;
            r_r_id    <= '0;
            r_r_addr  <= '0;
            r_r_len   <= '0;
            r_r_cnt   <= '0;
            r_r_size  <= '0;
            r_r_burst <= '0;
            r_r_err   <= 1'b0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (axi_req_i.ar_valid) begin
                        r_r_id    <= axi_req_i.ar.id;
                        r_r_addr  <= axi_req_i.ar.addr;
                        r_r_len   <= axi_req_i.ar.len;
                        r_r_size  <= axi_req_i.ar.size;
                        r_r_burst <= axi_req_i.ar.burst;
                        r_r_err   <= w_ar_err;
                        r_r_cnt   <= 8'd0;
                        r_r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_req_i.r_ready) begin
                        r_r_addr <= w_r_next_addr;
                        r_r_cnt  <= r_r_cnt + 8'd1;
                        if (r_r_cnt == r_r_len) begin
                            r_r_state <= R_IDLE;
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    // Reset forces every handshake and payload field to zero, even before the FSMs settle.
    always_comb begin
        axi_resp_o = '0;
        if (!rst_i) begin
            axi_resp_o.aw_ready = (r_w_state == W_IDLE);
            axi_resp_o.w_ready  = (r_w_state == W_DATA);
            axi_resp_o.b_valid  = (r_w_state == W_RESP);
            axi_resp_o.ar_ready = (r_r_state == R_IDLE);
            axi_resp_o.r_valid  = (r_r_state == R_DATA);
            if (r_w_state == W_RESP) begin
                axi_resp_o.b.id   = r_w_id;
                axi_resp_o.b.resp = r_w_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (r_r_state == R_DATA) begin
                axi_resp_o.r.id   = r_r_id;
                axi_resp_o.r.data = w_r_data;
                axi_resp_o.r.resp = {2'b00, (w_r_beat_ok ? RESP_OKAY : RESP_SLVERR)};
                axi_resp_o.r.last = (r_r_cnt == r_r_len);
            end
        end
    end
endmodule

// File: tb/tb_culsans_axi_scratchpad.sv
// Directed bench for culsans_axi_scratchpad: stimulus queues expected B/R responses,
// a negedge monitor pops and compares them on every handshake and checks stall stability.
module tb_culsans_axi_scratchpad;
    import culsans_pkg::*;

    localparam int unsigned NW    = 512;
    localparam logic [63:0] BASE  = DRAMBase;
    localparam logic [63:0] END_A = BASE + 64'(NW) * 64'd8;

    logic      clk;
    logic      rst;
    req_slv_t  req;
    resp_slv_t resp;

    culsans_axi_scratchpad #(.NumWords(NW), .BaseAddr(BASE)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req),
        .axi_resp_o (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } exp_b_t;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] data;
        logic [3:0]  resp;
        logic        last;
    } exp_r_t;

    exp_b_t b_q[$];
    exp_r_t r_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_b(input logic [7:0] id, input logic [1:0] rsp);
        exp_b_t e;
        e.id   = id;
        e.resp = rsp;
        b_q.push_back(e);
    endtask

    task automatic expect_r(input logic [7:0] id, input logic [63:0] data, input logic [3:0] rsp,
                            input logic last);
        exp_r_t e;
        e.id   = id;
        e.data = data;
        e.resp = rsp;
        e.last = last;
        r_q.push_back(e);
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [5:0] atop);
        int t;
        req.aw       = '0;
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = 3'd3;
        req.aw.burst = burst;
        req.aw.atop  = atop;
        req.aw_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!resp.aw_ready && t < 50);
        if (!resp.aw_ready) check("aw_accept_timeout", 128'(resp.aw_ready), 128'(1));
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int t;
        req.w      = '0;
        req.w.data = data;
        req.w.strb = strb;
        req.w.last = last;
        req.w_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!resp.w_ready && t < 50);
        if (!resp.w_ready) check("w_accept_timeout", 128'(resp.w_ready), 128'(1));
        tick();
        req.w_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int t;
        req.ar       = '0;
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = 3'd3;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!resp.ar_ready && t < 50);
        if (!resp.ar_ready) check("ar_accept_timeout", 128'(resp.ar_ready), 128'(1));
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("drain_timeout", 128'(b_q.size() + r_q.size()), 128'(0));
    endtask

    // Monitor: scoreboard pops on handshakes, plus hold checks for stalled B/R.
    logic    b_stall;
    logic    r_stall;
    b_chan_t b_hold;
    r_chan_t r_hold;
    initial begin
        exp_b_t eb;
        exp_r_t er;
        b_stall = 1'b0;
        r_stall = 1'b0;
        b_hold  = '0;
        r_hold  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                b_stall = 1'b0;
                r_stall = 1'b0;
            end else begin
                if (b_stall) begin
                    check("b_hold_valid", 128'(resp.b_valid), 128'(1));
                    check("b_hold_payload", 128'(resp.b), 128'(b_hold));
                end
                if (r_stall) begin
                    check("r_hold_valid", 128'(resp.r_valid), 128'(1));
                    check("r_hold_payload", 128'(resp.r), 128'(r_hold));
                end
                if (resp.b_valid && req.b_ready) begin
                    if (b_q.size() == 0) begin
                        check("b_unexpected_valid", 128'(resp.b_valid), 128'(0));
                    end else begin
                        eb = b_q.pop_front();
                        check("b_id", 128'(resp.b.id), 128'(eb.id));
                        check("b_resp", 128'(resp.b.resp), 128'(eb.resp));
                        check("b_user", 128'(resp.b.user), 128'(0));
                    end
                end
                if (resp.r_valid && req.r_ready) begin
                    if (r_q.size() == 0) begin
                        check("r_unexpected_valid", 128'(resp.r_valid), 128'(0));
                    end else begin
                        er = r_q.pop_front();
                        check("r_id", 128'(resp.r.id), 128'(er.id));
                        check("r_data", 128'(resp.r.data), 128'(er.data));
                        check("r_resp", 128'(resp.r.resp), 128'(er.resp));
                        check("r_last", 128'(resp.r.last), 128'(er.last));
                    end
                end
                b_stall = resp.b_valid && !req.b_ready;
                b_hold  = resp.b;
                r_stall = resp.r_valid && !req.r_ready;
                r_hold  = resp.r;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", 128'(resp), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_aw_ready", 128'(resp.aw_ready), 128'(1));
        check("post_reset_ar_ready", 128'(resp.ar_ready), 128'(1));
        check("post_reset_w_ready", 128'(resp.w_ready), 128'(0));
        tick();

        // Single write then read.
        expect_b(8'h2A, RESP_OKAY);
        send_aw(8'h2A, BASE + 64'h10, 8'd0, BURST_INCR, 6'd0);
        check("aw_ready_low_in_data", 128'(resp.aw_ready), 128'(0));
        check("w_ready_after_aw", 128'(resp.w_ready), 128'(1));
        send_w(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
        check("b_latency", 128'(resp.b_valid), 128'(1));
        drain();
        expect_r(8'h15, 64'hDEADBEEF_CAFEF00D, 4'b0000, 1'b1);
        send_ar(8'h15, BASE + 64'h10, 8'd0, BURST_INCR);
        check("r_latency", 128'(resp.r_valid), 128'(1));
        check("ar_ready_low_in_data", 128'(resp.ar_ready), 128'(0));
        drain();

        // INCR burst, read back under r_ready backpressure.
        expect_b(8'h03, RESP_OKAY);
        send_aw(8'h03, BASE + 64'h100, 8'd3, BURST_INCR, 6'd0);
        for (int i = 0; i < 4; i++) send_w(64'(i + 1), 8'hFF, i == 3);
        drain();
        for (int i = 0; i < 4; i++) expect_r(8'h04, 64'(i + 1), 4'b0000, i == 3);
        send_ar(8'h04, BASE + 64'h100, 8'd3, BURST_INCR);
        for (int i = 0; i < 10; i++) begin
            req.r_ready = (i % 2 == 0);
            tick();
        end
        req.r_ready = 1'b1;
        drain();

        // Byte strobes.
        expect_b(8'h05, RESP_OKAY);
        send_aw(8'h05, BASE + 64'h200, 8'd0, BURST_INCR, 6'd0);
        send_w(64'h1111_1111_2222_2222, 8'hFF, 1'b1);
        drain();
        expect_b(8'h06, RESP_OKAY);
        send_aw(8'h06, BASE + 64'h200, 8'd0, BURST_INCR, 6'd0);
        send_w(64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1);
        drain();
        expect_r(8'h07, 64'h1111_1111_BBBB_BBBB, 4'b0000, 1'b1);
        send_ar(8'h07, BASE + 64'h200, 8'd0, BURST_INCR);
        drain();

        // Out-of-range write must not alias onto word 0.
        expect_b(8'h08, RESP_OKAY);
        send_aw(8'h08, BASE, 8'd0, BURST_INCR, 6'd0);
        send_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        drain();
        expect_b(8'h09, RESP_SLVERR);
        send_aw(8'h09, END_A, 8'd0, BURST_INCR, 6'd0);
        send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        drain();
        expect_r(8'h0A, 64'h0123_4567_89AB_CDEF, 4'b0000, 1'b1);
        send_ar(8'h0A, BASE, 8'd0, BURST_INCR);
        drain();

        // Read crossing the top of the window.
        expect_b(8'h0B, RESP_OKAY);
        send_aw(8'h0B, END_A - 64'd8, 8'd0, BURST_INCR, 6'd0);
        send_w(64'h55, 8'hFF, 1'b1);
        drain();
        expect_r(8'h0C, 64'h55, 4'b0000, 1'b0);
        expect_r(8'h0C, 64'h0, 4'b0010, 1'b1);
        send_ar(8'h0C, END_A - 64'd8, 8'd1, BURST_INCR);
        drain();

        // WRAP read, early W last, atomic write.
        expect_r(8'h0D, 64'h0, 4'b0010, 1'b0);
        expect_r(8'h0D, 64'h0, 4'b0010, 1'b1);
        send_ar(8'h0D, BASE + 64'h10, 8'd1, BURST_WRAP);
        drain();
        expect_b(8'h0E, RESP_SLVERR);
        send_aw(8'h0E, BASE + 64'h300, 8'd3, BURST_INCR, 6'd0);
        send_w(64'h1234, 8'hFF, 1'b0);
        send_w(64'h5678, 8'hFF, 1'b1);
        check("b_after_early_last", 128'(resp.b_valid), 128'(1));
        check("w_ready_after_early_last", 128'(resp.w_ready), 128'(0));
        drain();
        expect_b(8'h0F, RESP_SLVERR);
        send_aw(8'h0F, BASE + 64'h308, 8'd0, BURST_INCR, 6'h20);
        send_w(64'h9999, 8'hFF, 1'b1);
        drain();

        // Simultaneous AW/AR, B held off for 5 cycles.
        expect_r(8'h11, 64'hDEADBEEF_CAFEF00D, 4'b0000, 1'b1);
        expect_b(8'h10, RESP_OKAY);
        req.aw       = '0;
        req.aw.id    = 8'h10;
        req.aw.addr  = BASE + 64'h400;
        req.aw.size  = 3'd3;
        req.aw.burst = BURST_INCR;
        req.ar       = '0;
        req.ar.id    = 8'h11;
        req.ar.addr  = BASE + 64'h10;
        req.ar.size  = 3'd3;
        req.ar.burst = BURST_INCR;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        req.b_ready  = 1'b0;
        @(negedge clk);
        check("concurrent_aw_ready", 128'(resp.aw_ready), 128'(1));
        check("concurrent_ar_ready", 128'(resp.ar_ready), 128'(1));
        tick();
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        send_w(64'h77, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("aw_ready_during_b_stall", 128'(resp.aw_ready), 128'(0));
        end
        check("read_done_during_b_stall", 128'(r_q.size()), 128'(0));
        tick();
        req.b_ready = 1'b1;
        drain();

        // Reset in the middle of a 4-beat read.
        expect_r(8'h12, 64'd1, 4'b0000, 1'b0);
        expect_r(8'h12, 64'd2, 4'b0000, 1'b0);
        send_ar(8'h12, BASE + 64'h100, 8'd3, BURST_INCR);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("r_valid_in_reset", 128'(resp.r_valid), 128'(0));
        check("resp_zero_in_reset", 128'(resp), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ar_ready_after_abort", 128'(resp.ar_ready), 128'(1));
        check("r_valid_after_abort", 128'(resp.r_valid), 128'(0));
        repeat (5) tick();
        check("beats_before_abort", 128'(r_q.size()), 128'(0));
        expect_r(8'h13, 64'd2, 4'b0000, 1'b1);
        send_ar(8'h13, BASE + 64'h108, 8'd0, BURST_INCR);
        drain();

        repeat (3) tick();
        check("queues_empty_at_end", 128'(b_q.size() + r_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
